// File: rtl/ecr_allocator.sv
// ecr_allocator: issue-side allocator for execution condition registers.
// Grants the lowest free ECR to each issued branch and writes Busy into the
// ECR file for it. Tracks the ECR that new instructions depend on and keeps a
// reference count per ECR. An ECR is recycled once it is resolved,
// unreferenced and no longer current.

module ecr_allocator_chk #(
    parameter int NUM_ECRS = 2
) (
    input logic                clk,
    input logic                rst_n,
    input logic [NUM_ECRS-1:0] i_uflow
);

    // A release must never find the reference counter already at zero.
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) i_uflow == {NUM_ECRS{1'b0}})
        else $error("ecr_allocator: reference counter underflow");

endmodule

module ecr_allocator #(
    parameter int NUM_ECRS  = 2,
    parameter int NUM_SICS  = 2,
    parameter int REF_WIDTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  alloc_req,
    output logic                                  alloc_ready,
    output logic [$clog2(NUM_ECRS)-1:0]           alloc_id,
    input  logic                                  acq_req,
    output logic                                  acq_ready,
    output logic [$clog2(NUM_ECRS)-1:0]           cur_ecr_id,
    input  logic [NUM_SICS-1:0]                   rel_valid,
    input  logic [NUM_SICS*$clog2(NUM_ECRS)-1:0]  rel_id,
    input  logic [2*NUM_ECRS-1:0]                 ecr_states,
    output logic                                  issue_wen,
    output logic [$clog2(NUM_ECRS)-1:0]           issue_write_addr,
    output logic [1:0]                            issue_wdata,
    output logic [$clog2(NUM_ECRS):0]             free_count
);

    localparam int IW   = $clog2(NUM_ECRS);
    localparam int CNTW = IW + 1;
    localparam int RCW  = $clog2(NUM_SICS + 1);
    localparam int SW   = ((REF_WIDTH > RCW) ? REF_WIDTH : RCW) + 1;
    localparam logic [REF_WIDTH-1:0] REF_MAX = {REF_WIDTH{1'b1}};

    // PENDING covers the cycle in which the ECR file write is still landing,
    // so a stale resolved value cannot reclaim a freshly granted ECR.
    typedef enum logic [1:0] {
        ST_FREE    = 2'b00,
        ST_PENDING = 2'b01,
        ST_LIVE    = 2'b10
    } ecr_st_e;

    ecr_st_e              r_state      [NUM_ECRS];
    logic [REF_WIDTH-1:0] r_refcnt     [NUM_ECRS];
    logic [IW-1:0]        r_cur;
    logic [CNTW-1:0]      r_free_count;

    ecr_st_e              w_state_nxt  [NUM_ECRS];
    logic [REF_WIDTH-1:0] w_refcnt_nxt [NUM_ECRS];
    logic [SW-1:0]        w_rel_cnt    [NUM_ECRS];
    logic [SW-1:0]        w_sum        [NUM_ECRS];
    logic [NUM_ECRS-1:0]  w_uflow;
    logic [IW-1:0]        w_alloc_id;
    logic [IW-1:0]        w_cur_nxt;
    logic [CNTW-1:0]      w_free_count_nxt;
    logic                 w_any_free;
    logic                 w_alloc_fire;
    logic                 w_acq_ready;
    logic                 w_acq_fire;

    // Lowest-index FREE ECR is the grant candidate.
    always_comb begin
        w_alloc_id = {IW{1'b0}};
        w_any_free = 1'b0;
        for (int k = NUM_ECRS - 1; k >= 0; k--) begin
            if (r_state[k] == ST_FREE) begin
                w_alloc_id = IW'(k);
                w_any_free = 1'b1;
            end else begin
                w_alloc_id = w_alloc_id;
                w_any_free = w_any_free;
            end
        end
    end

    // Handshakes; reset gates the write enable so it drops immediately.
    always_comb begin
        w_alloc_fire = alloc_req && w_any_free && rst_n;
        w_acq_ready  = (r_refcnt[r_cur] != REF_MAX);
        w_acq_fire   = acq_req && w_acq_ready;
        w_cur_nxt    = w_alloc_fire ? w_alloc_id : r_cur;
    end

    // Count returned references per ECR; out-of-range ids match nothing.
    always_comb begin
        for (int k = 0; k < NUM_ECRS; k++) begin
            w_rel_cnt[k] = {SW{1'b0}};
            for (int i = 0; i < NUM_SICS; i++) begin
                if (rel_valid[i] && (rel_id[i*IW +: IW] == IW'(k))) begin
                    w_rel_cnt[k] = w_rel_cnt[k] + SW'(1'b1);
                end else begin
                    w_rel_cnt[k] = w_rel_cnt[k];
                end
            end
        end
    end

    // Net acquire/release per ECR, holding at zero instead of wrapping.
    always_comb begin
        for (int k = 0; k < NUM_ECRS; k++) begin
            w_sum[k] = SW'(r_refcnt[k]) + ((w_acq_fire && (r_cur == IW'(k))) ? SW'(1'b1) : SW'(1'b0));
            if (w_rel_cnt[k] > w_sum[k]) begin
                w_uflow[k]      = 1'b1;
                w_refcnt_nxt[k] = {REF_WIDTH{1'b0}};
            end else begin
                w_uflow[k]      = 1'b0;
                w_refcnt_nxt[k] = REF_WIDTH'(w_sum[k] - w_rel_cnt[k]);
            end
        end
    end

    // Per-ECR lifecycle: grant, settle, and reclaim when resolved and idle.
    always_comb begin
        for (int k = 0; k < NUM_ECRS; k++) begin
            w_state_nxt[k] = r_state[k];
            case (r_state[k])
                ST_FREE: begin
                    if (w_alloc_fire && (w_alloc_id == IW'(k))) begin
                        w_state_nxt[k] = ST_PENDING;
                    end else begin
                        w_state_nxt[k] = ST_FREE;
                    end
                end
                ST_PENDING: begin
                    w_state_nxt[k] = ST_LIVE;
                end
                ST_LIVE: begin
                    if ((ecr_states[2*k +: 2] != 2'b00) && (w_cur_nxt != IW'(k)) &&
                        (w_refcnt_nxt[k] == {REF_WIDTH{1'b0}})) begin
                        w_state_nxt[k] = ST_FREE;
                    end else begin
                        w_state_nxt[k] = ST_LIVE;
                    end
                end
                default: begin
                    w_state_nxt[k] = ST_FREE;
                end
            endcase
        end
    end

    // Population count of FREE ECRs after this edge.
    always_comb begin
        w_free_count_nxt = {CNTW{1'b0}};
        for (int k = 0; k < NUM_ECRS; k++) begin
            if (w_state_nxt[k] == ST_FREE) begin
                w_free_count_nxt = w_free_count_nxt + CNTW'(1'b1);
            end else begin
                w_free_count_nxt = w_free_count_nxt;
            end
        end
    end

    // State registers; ECR 0 comes out of reset live and current.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur        <= {IW{1'b0}};
            r_free_count <= CNTW'(NUM_ECRS - 1);
            for (int k = 0; k < NUM_ECRS; k++) begin
                r_state[k]  <= (k == 0) ? ST_LIVE : ST_FREE;
                r_refcnt[k] <= {REF_WIDTH{1'b0}};
            end
        end else begin
            r_cur        <= w_cur_nxt;
            r_free_count <= w_free_count_nxt;
            for (int k = 0; k < NUM_ECRS; k++) begin
                r_state[k]  <= w_state_nxt[k];
                r_refcnt[k] <= w_refcnt_nxt[k];
            end
        end
    end

    assign alloc_ready      = w_any_free;
    assign alloc_id         = w_alloc_id;
    assign acq_ready        = w_acq_ready;
    assign cur_ecr_id       = r_cur;
    assign issue_wen        = w_alloc_fire;
    assign issue_write_addr = w_alloc_fire ? w_alloc_id : {IW{1'b0}};
    assign issue_wdata      = 2'b00;
    assign free_count       = r_free_count;

    ecr_allocator_chk #(.NUM_ECRS(NUM_ECRS)) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_uflow (w_uflow)
    );

endmodule

// File: tb/tb_ecr_allocator.sv
// Self-checking bench for ecr_allocator (NUM_ECRS=2, NUM_SICS=2, REF_WIDTH=2).
// Directed scenarios plus randomized traffic against a set/usage-level model.

module tb_ecr_allocator;

    localparam int N    = 2;
    localparam int S    = 2;
    localparam int RW   = 2;
    localparam int IW   = 1;
    localparam int MAXC = 3;

    logic            clk;
    logic            rst_n;
    logic            alloc_req;
    logic            acq_req;
    logic [S-1:0]    rel_valid;
    logic [S*IW-1:0] rel_id;
    logic [2*N-1:0]  ecr_states;
    logic            alloc_ready;
    logic            acq_ready;
    logic            issue_wen;
    logic [IW-1:0]   alloc_id;
    logic [IW-1:0]   cur_ecr_id;
    logic [IW-1:0]   issue_write_addr;
    logic [1:0]      issue_wdata;
    logic [IW:0]     free_count;

    int n_cmp;
    int n_bad;

    // Model: which ECRs are handed out, which were granted in the last cycle,
    // how many references each holds, and the current dependency ECR.
    int m_cur;
    int m_refs  [N];
    bit m_used  [N];
    bit m_fresh [N];

    ecr_allocator #(.NUM_ECRS(N), .NUM_SICS(S), .REF_WIDTH(RW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .alloc_req        (alloc_req),
        .alloc_ready      (alloc_ready),
        .alloc_id         (alloc_id),
        .acq_req          (acq_req),
        .acq_ready        (acq_ready),
        .cur_ecr_id       (cur_ecr_id),
        .rel_valid        (rel_valid),
        .rel_id           (rel_id),
        .ecr_states       (ecr_states),
        .issue_wen        (issue_wen),
        .issue_write_addr (issue_write_addr),
        .issue_wdata      (issue_wdata),
        .free_count       (free_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int m_first_free();
        for (int k = 0; k < N; k++) begin
            if (!m_used[k]) return k;
        end
        return -1;
    endfunction

    function automatic int m_nfree();
        int c;
        c = 0;
        for (int k = 0; k < N; k++) begin
            if (!m_used[k]) c++;
        end
        return c;
    endfunction

    task automatic m_reset();
        m_cur = 0;
        for (int k = 0; k < N; k++) begin
            m_refs[k]  = 0;
            m_used[k]  = (k == 0);
            m_fresh[k] = 1'b0;
        end
    endtask

    task automatic m_edge();
        int g;
        int ncur;
        int r;
        g = m_first_free();
        if (acq_req && m_refs[m_cur] < MAXC) m_refs[m_cur]++;
        for (int i = 0; i < S; i++) begin
            r = int'(rel_id[i*IW +: IW]);
            if (rel_valid[i] && r < N && m_refs[r] > 0) m_refs[r]--;
        end
        ncur = (alloc_req && g >= 0) ? g : m_cur;
        for (int k = 0; k < N; k++) begin
            if (m_used[k] && !m_fresh[k] && ecr_states[2*k +: 2] != 2'b00 && k != ncur && m_refs[k] == 0)
                m_used[k] = 1'b0;
            m_fresh[k] = 1'b0;
        end
        if (alloc_req && g >= 0) begin
            m_used[g]  = 1'b1;
            m_fresh[g] = 1'b1;
        end
        m_cur = ncur;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        else m_reset();
        #1;
    endtask

    task automatic drive(input logic a, input logic q, input logic [S-1:0] rv,
                         input logic [S*IW-1:0] rid, input logic [2*N-1:0] st);
        alloc_req  = a;
        acq_req    = q;
        rel_valid  = rv;
        rel_id     = rid;
        ecr_states = st;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 2'b00, 4'b0001);
        m_reset();
        #12;
        n_cmp++; if (cur_ecr_id !== 1'b0) begin n_bad++; $display("FAIL reset_cur: got %0d want 0", cur_ecr_id); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL reset_alloc_ready: got %0d want 1", alloc_ready); end
        n_cmp++; if (alloc_id !== 1'b1) begin n_bad++; $display("FAIL reset_alloc_id: got %0d want 1", alloc_id); end
        n_cmp++; if (issue_wen !== 1'b0) begin n_bad++; $display("FAIL reset_wen: got %0d want 0", issue_wen); end
        n_cmp++; if (issue_write_addr !== 1'b0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", issue_write_addr); end
        n_cmp++; if (free_count !== 2'd1) begin n_bad++; $display("FAIL reset_free_count: got %0d want 1", free_count); end
        n_cmp++; if (acq_ready !== 1'b1) begin n_bad++; $display("FAIL reset_acq_ready: got %0d want 1", acq_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alloc_basic();
        // Branch issue with an acquire in the same cycle: the reference goes to ECR 0.
        drive(1'b1, 1'b1, 2'b00, 2'b00, 4'b0001);
        #1;
        n_cmp++; if (issue_wen !== 1'b1) begin n_bad++; $display("FAIL alloc_wen: got %0d want 1", issue_wen); end
        n_cmp++; if (issue_write_addr !== 1'b1) begin n_bad++; $display("FAIL alloc_addr: got %0d want 1", issue_write_addr); end
        n_cmp++; if (issue_wdata !== 2'b00) begin n_bad++; $display("FAIL alloc_wdata: got %0d want 0", issue_wdata); end
        tick();
        drive(1'b0, 1'b0, 2'b00, 2'b00, 4'b0001);
        #1;
        n_cmp++; if (cur_ecr_id !== 1'b1) begin n_bad++; $display("FAIL alloc_cur: got %0d want 1", cur_ecr_id); end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL alloc_ready_low: got %0d want 0", alloc_ready); end
        n_cmp++; if (free_count !== 2'd0) begin n_bad++; $display("FAIL alloc_free_count: got %0d want 0", free_count); end
        n_cmp++; if (issue_wen !== 1'b0) begin n_bad++; $display("FAIL alloc_wen_idle: got %0d want 0", issue_wen); end
        tick();
        drive(1'b0, 1'b0, 2'b01, 2'b00, 4'b0001);
        tick();
        drive(1'b0, 1'b0, 2'b00, 2'b00, 4'b0001);
        #1;
        n_cmp++; if (free_count !== 2'd1) begin n_bad++; $display("FAIL old_freed_count: got %0d want 1", free_count); end
        n_cmp++; if (alloc_id !== 1'b0) begin n_bad++; $display("FAIL old_freed_id: got %0d want 0", alloc_id); end
        tick();
    endtask

    task automatic test_refcount_reclaim();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 2'b00, 2'b00, 4'b0001);
            #1;
            n_cmp++; if (acq_ready !== 1'b1) begin n_bad++; $display("FAIL acq_ready_below_max: got %0d want 1 (step %0d)", acq_ready, i); end
            tick();
        end
        drive(1'b0, 1'b1, 2'b00, 2'b00, 4'b0001);
        #1;
        n_cmp++; if (acq_ready !== 1'b0) begin n_bad++; $display("FAIL acq_ready_at_max: got %0d want 0", acq_ready); end
        tick();
        drive(1'b1, 1'b0, 2'b00, 2'b00, 4'b0101);
        #1;
        n_cmp++; if (alloc_id !== 1'b0) begin n_bad++; $display("FAIL rc_alloc_id: got %0d want 0", alloc_id); end
        n_cmp++; if (issue_wen !== 1'b1) begin n_bad++; $display("FAIL rc_wen: got %0d want 1", issue_wen); end
        tick();
        drive(1'b0, 1'b0, 2'b01, 2'b01, 4'b0101);
        #1;
        n_cmp++; if (cur_ecr_id !== 1'b0) begin n_bad++; $display("FAIL rc_cur: got %0d want 0", cur_ecr_id); end
        n_cmp++; if (free_count !== 2'd0) begin n_bad++; $display("FAIL rc_held_3: got %0d want 0", free_count); end
        tick();
        // Both SICs return a reference to ECR 1 in one cycle (2 -> 0).
        drive(1'b0, 1'b0, 2'b11, 2'b11, 4'b0101);
        #1;
        n_cmp++; if (free_count !== 2'd0) begin n_bad++; $display("FAIL rc_held_2: got %0d want 0", free_count); end
        tick();
        drive(1'b0, 1'b0, 2'b00, 2'b00, 4'b0101);
        #1;
        n_cmp++; if (free_count !== 2'd1) begin n_bad++; $display("FAIL rc_freed_count: got %0d want 1", free_count); end
        n_cmp++; if (alloc_id !== 1'b1) begin n_bad++; $display("FAIL rc_freed_id: got %0d want 1", alloc_id); end
        tick();
    endtask

    task automatic test_acq_rel_net();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 2'b00, 2'b00, 4'b0101);
            tick();
        end
        drive(1'b0, 1'b1, 2'b01, 2'b00, 4'b0101);
        tick();
        drive(1'b0, 1'b0, 2'b00, 2'b00, 4'b0101);
        #1;
        n_cmp++; if (acq_ready !== 1'b1) begin n_bad++; $display("FAIL net_ready_at_2: got %0d want 1", acq_ready); end
        drive(1'b0, 1'b1, 2'b00, 2'b00, 4'b0101);
        tick();
        drive(1'b0, 1'b0, 2'b00, 2'b00, 4'b0101);
        #1;
        n_cmp++; if (acq_ready !== 1'b0) begin n_bad++; $display("FAIL net_ready_at_3: got %0d want 0", acq_ready); end
        drive(1'b0, 1'b0, 2'b11, 2'b00, 4'b0101);
        tick();
        drive(1'b0, 1'b0, 2'b01, 2'b00, 4'b0101);
        tick();
        drive(1'b0, 1'b0, 2'b00, 2'b00, 4'b0101);
        #1;
        n_cmp++; if (acq_ready !== 1'b1) begin n_bad++; $display("FAIL net_drained: got %0d want 1", acq_ready); end
        tick();
    endtask

    task automatic test_stale_pending();
        drive(1'b1, 1'b0, 2'b00, 2'b00, 4'b1001);
        #1;
        n_cmp++; if (alloc_id !== 1'b1) begin n_bad++; $display("FAIL stale_first_id: got %0d want 1", alloc_id); end
        tick();
        // ECR 1 is PENDING and its file entry still reads 10; grant ECR 0 over it.
        drive(1'b1, 1'b0, 2'b00, 2'b00, 4'b1001);
        #1;
        n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL stale_ready: got %0d want 1", alloc_ready); end
        n_cmp++; if (alloc_id !== 1'b0) begin n_bad++; $display("FAIL stale_second_id: got %0d want 0", alloc_id); end
        n_cmp++; if (cur_ecr_id !== 1'b1) begin n_bad++; $display("FAIL stale_cur1: got %0d want 1", cur_ecr_id); end
        tick();
        drive(1'b0, 1'b0, 2'b00, 2'b00, 4'b0001);
        #1;
        n_cmp++; if (free_count !== 2'd0) begin n_bad++; $display("FAIL stale_masked: got %0d want 0", free_count); end
        n_cmp++; if (cur_ecr_id !== 1'b0) begin n_bad++; $display("FAIL stale_cur0: got %0d want 0", cur_ecr_id); end
        tick();
        drive(1'b0, 1'b0, 2'b00, 2'b00, 4'b1000);
        #1;
        n_cmp++; if (free_count !== 2'd0) begin n_bad++; $display("FAIL stale_busy_held: got %0d want 0", free_count); end
        tick();
        #1;
        n_cmp++; if (free_count !== 2'd1) begin n_bad++; $display("FAIL stale_reclaimed: got %0d want 1", free_count); end
        n_cmp++; if (alloc_id !== 1'b1) begin n_bad++; $display("FAIL stale_reclaimed_id: got %0d want 1", alloc_id); end
        tick();
    endtask

    task automatic test_random();
        int plan [N];
        int r;
        int g;
        for (int c = 0; c < 400; c++) begin
            alloc_req = ($urandom_range(0, 3) == 0);
            acq_req   = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < N; k++) plan[k] = m_refs[k];
            for (int i = 0; i < S; i++) begin
                r = $urandom_range(0, N - 1);
                if (plan[r] > 0 && $urandom_range(0, 1) == 1) begin
                    rel_valid[i] = 1'b1;
                    plan[r]--;
                end else begin
                    rel_valid[i] = 1'b0;
                end
                rel_id[i*IW +: IW] = IW'(r);
            end
            for (int k = 0; k < N; k++) ecr_states[2*k +: 2] = 2'($urandom_range(0, 2));
            #1;
            g = m_first_free();
            n_cmp++; if (alloc_ready !== (g >= 0)) begin n_bad++; $display("FAIL rnd_alloc_ready: cyc %0d got %0d want %0d", c, alloc_ready, g >= 0); end
            if (g >= 0) begin
                n_cmp++; if (alloc_id !== IW'(g)) begin n_bad++; $display("FAIL rnd_alloc_id: cyc %0d got %0d want %0d", c, alloc_id, g); end
            end
            n_cmp++; if (issue_wen !== (alloc_req && g >= 0)) begin n_bad++; $display("FAIL rnd_wen: cyc %0d got %0d want %0d", c, issue_wen, alloc_req && g >= 0); end
            if (alloc_req && g >= 0) begin
                n_cmp++; if (issue_write_addr !== IW'(g)) begin n_bad++; $display("FAIL rnd_addr: cyc %0d got %0d want %0d", c, issue_write_addr, g); end
            end
            n_cmp++; if (cur_ecr_id !== IW'(m_cur)) begin n_bad++; $display("FAIL rnd_cur: cyc %0d got %0d want %0d", c, cur_ecr_id, m_cur); end
            n_cmp++; if (acq_ready !== (m_refs[m_cur] < MAXC)) begin n_bad++; $display("FAIL rnd_acq_ready: cyc %0d got %0d want %0d", c, acq_ready, m_refs[m_cur] < MAXC); end
            n_cmp++; if (free_count !== (IW+1)'(m_nfree())) begin n_bad++; $display("FAIL rnd_free_count: cyc %0d got %0d want %0d", c, free_count, m_nfree()); end
            n_cmp++; if (issue_wdata !== 2'b00) begin n_bad++; $display("FAIL rnd_wdata: cyc %0d got %0d want 0", c, issue_wdata); end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b0, 1'b1, 2'b00, 2'b00, 4'b0101);
        tick();
        tick();
        drive(1'b1, 1'b1, 2'b00, 2'b00, 4'b0101);
        #1;
        n_cmp++; if (issue_wen !== (m_first_free() >= 0)) begin n_bad++; $display("FAIL mid_wen_before: got %0d want %0d", issue_wen, m_first_free() >= 0); end
        #1;
        rst_n = 1'b0;
        #1;
        m_reset();
        n_cmp++; if (issue_wen !== 1'b0) begin n_bad++; $display("FAIL mid_wen: got %0d want 0", issue_wen); end
        n_cmp++; if (cur_ecr_id !== 1'b0) begin n_bad++; $display("FAIL mid_cur: got %0d want 0", cur_ecr_id); end
        n_cmp++; if (free_count !== 2'd1) begin n_bad++; $display("FAIL mid_free_count: got %0d want 1", free_count); end
        n_cmp++; if (alloc_id !== 1'b1) begin n_bad++; $display("FAIL mid_alloc_id: got %0d want 1", alloc_id); end
        n_cmp++; if (acq_ready !== 1'b1) begin n_bad++; $display("FAIL mid_acq_ready: got %0d want 1", acq_ready); end
        drive(1'b0, 1'b0, 2'b00, 2'b00, 4'b0001);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        n_cmp++; if (free_count !== 2'd1) begin n_bad++; $display("FAIL mid_after_release: got %0d want 1", free_count); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_alloc_basic();
        test_refcount_reclaim();
        test_acq_rel_net();
        test_stale_pending();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within the time limit");
        $fatal(1);
    end

endmodule
